// File: rtl/midi_cmd_encoder.sv
// MIDI byte stream to 16-bit synthesizer command words, emitted as word/hold/gap pulses.
// Optional all-notes-off (CC 123) support is enabled by defining MIDI_ALL_NOTES_OFF_EN.
module midi_cmd_encoder #(
   parameter int CHANNEL     = 0,
   parameter int HOLD_CYCLES = 2,
   parameter int GAP_CYCLES  = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    i_byte,
   input  logic                          i_byte_valid,
   output logic                          o_byte_ready,
   output logic [15:0]                   o_data,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;
   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [3:0] CH = CHANNEL[3:0];

   localparam logic [1:0] P_IDLE  = 2'd0;
   localparam logic [1:0] P_DATA1 = 2'd1;
   localparam logic [1:0] P_DATA2 = 2'd2;
   localparam logic [1:0] P_SKIP  = 2'd3;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam logic [1:0] K_NONE = 2'd0;
   localparam logic [1:0] K_ON   = 2'd1;
   localparam logic [1:0] K_OFF  = 2'd2;
`ifdef MIDI_ALL_NOTES_OFF_EN
   localparam logic [1:0] K_CC   = 2'd3;
`endif

   logic [1:0]    p_state;
   logic [1:0]    rs_kind;
   logic [6:0]    note;
   logic [1:0]    s_state;
   logic [TW-1:0] timer;

   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] count;

   logic          accept;
   logic          is_data;
   logic          is_rt;
   logic          is_sys;
   logic          is_on;
   logic          is_off;
`ifdef MIDI_ALL_NOTES_OFF_EN
   logic          is_cc;
`endif
   logic          push;
   logic          pop;
   logic          word_ok;
   logic [15:0]   word;
   logic [6:0]    vel;

   assign o_byte_ready = (count != LW'(FIFO_DEPTH));
   assign o_fifo_level = count;
   assign o_busy       = (count != '0) || (s_state != S_IDLE);

   assign accept  = i_byte_valid && o_byte_ready;
   assign is_data = !i_byte[7];
   assign is_rt   = (i_byte[7:3] == 5'b11111);
   assign is_sys  = (i_byte[7:4] == 4'hF) && !i_byte[3];
   assign is_on   = (i_byte[7:4] == 4'h9) && (i_byte[3:0] == CH);
   assign is_off  = (i_byte[7:4] == 4'h8) && (i_byte[3:0] == CH);
`ifdef MIDI_ALL_NOTES_OFF_EN
   assign is_cc   = (i_byte[7:4] == 4'hB) && (i_byte[3:0] == CH);
`endif
   assign vel     = i_byte[6:0];

   // Word is built from the byte being accepted so the push lands on that same edge.
   always_comb begin
      word    = '0;
      word_ok = 1'b0;
      case (rs_kind)
         K_ON: begin
            word_ok = 1'b1;
            word    = (vel != 7'd0) ? {2'b01, note, vel} : {2'b10, note, 7'd0};
         end
         K_OFF: begin
            word_ok = 1'b1;
            word    = {2'b10, note, vel};
         end
`ifdef MIDI_ALL_NOTES_OFF_EN
         K_CC: begin
            word_ok = (note == 7'd123);
            word    = 16'hC000;
         end
`endif
         default: ;
      endcase
   end

   assign push = accept && is_data && (p_state == P_DATA2) && word_ok;
   assign pop  = (s_state == S_IDLE) && (count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_state <= P_IDLE;
         rs_kind <= K_NONE;
         note    <= '0;
      end else if (accept) begin
         if (is_rt) begin
            p_state <= p_state;
         end else if (is_sys) begin
            p_state <= P_IDLE;
            rs_kind <= K_NONE;
         end else if (is_on) begin
            p_state <= P_DATA1;
            rs_kind <= K_ON;
         end else if (is_off) begin
            p_state <= P_DATA1;
            rs_kind <= K_OFF;
`ifdef MIDI_ALL_NOTES_OFF_EN
         end else if (is_cc) begin
            p_state <= P_DATA1;
            rs_kind <= K_CC;
`endif
         end else if (!is_data) begin
            p_state <= P_SKIP;
            rs_kind <= K_NONE;
         end else begin
            case (p_state)
               P_DATA1: begin
                  note    <= i_byte[6:0];
                  p_state <= P_DATA2;
               end
               P_DATA2: p_state <= P_DATA1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Hold then gap: every word is framed by zeros so repeated commands retrigger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_state <= S_IDLE;
         timer   <= '0;
         rd_ptr  <= '0;
         o_data  <= '0;
      end else begin
         case (s_state)
            S_IDLE: begin
               if (pop) begin
                  o_data  <= mem[rd_ptr];
                  rd_ptr  <= rd_ptr + AW'(1);
                  timer   <= TW'(HOLD_CYCLES - 1);
                  s_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (timer == '0) begin
                  o_data  <= '0;
                  timer   <= TW'(GAP_CYCLES - 1);
                  s_state <= S_GAP;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_GAP: begin
               if (timer == '0) s_state <= S_IDLE;
               else             timer   <= timer - TW'(1);
            end
            default: s_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_midi_cmd_encoder.sv
// Bench for midi_cmd_encoder: directed test-plan steps plus random byte streams against a
// message-level reference model (parse rules, word queue, emission schedule).
module tb_midi_cmd_encoder;

   localparam int CH = 0;
   localparam int H  = 2;
   localparam int G  = 1;
   localparam int D  = 4;
   localparam int LW = $clog2(D) + 1;
`ifdef MIDI_ALL_NOTES_OFF_EN
   localparam bit AON = 1'b1;
`else
   localparam bit AON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    i_byte = 8'h00;
   logic          i_byte_valid = 1'b0;
   logic          o_byte_ready;
   logic [15:0]   o_data;
   logic          o_busy;
   logic [LW-1:0] o_fifo_level;

   always #5 clk = ~clk;

   midi_cmd_encoder #(
      .CHANNEL(CH), .HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
      .o_byte_ready(o_byte_ready), .o_data(o_data), .o_busy(o_busy),
      .o_fifo_level(o_fifo_level)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: word queue plus emission times; a word appears at its pop edge.
   logic [15:0] q[$];
   logic [15:0] cur = 16'h0;
   int          k = 0;
   int          emit = -1000;
   int          next_free = 0;
   logic [7:0]  rs = 8'h00;
   int          phase = 0;
   logic [6:0]  mnote = 7'd0;
   bit          acc;
   bit          saw_not_ready;
   bit          saw_word;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, output bit p, output logic [15:0] w);
      p = 1'b0;
      w = 16'h0;
      if (b >= 8'hF8) begin
      end else if (b >= 8'hF0) begin
         rs = 8'h00; phase = 0;
      end else if (b[7]) begin
         if (b == 8'h90 + 8'(CH) || b == 8'h80 + 8'(CH) || (AON && b == 8'hB0 + 8'(CH))) begin
            rs = b; phase = 1;
         end else begin
            rs = 8'h00; phase = 0;
         end
      end else if (phase == 1) begin
         mnote = b[6:0]; phase = 2;
      end else if (phase == 2) begin
         phase = 1;
         if (rs[7:4] == 4'h9) begin
            p = 1'b1;
            w = (b != 8'h00) ? {2'b01, mnote, b[6:0]} : {2'b10, mnote, 7'd0};
         end else if (rs[7:4] == 4'h8) begin
            p = 1'b1;
            w = {2'b10, mnote, b[6:0]};
         end else if (mnote == 7'd123) begin
            p = 1'b1;
            w = 16'hC000;
         end
      end
   endtask

   task automatic model_reset();
      q.delete();
      emit = -1000;
      next_free = 0;
      rs = 8'h00;
      phase = 0;
      cur = 16'h0;
   endtask

   // One clock: drive, compare at the falling edge, advance the model at the rising edge.
   task automatic cycle(input logic v, input logic [7:0] b);
      bit          p;
      logic [15:0] w;
      logic [15:0] ed;
      int          e;
      i_byte_valid = v;
      i_byte = b;
      @(negedge clk);
      e = k - 1;
      ed = (emit <= e && e < emit + H) ? cur : 16'h0;
      chk("data", o_data, ed);
      chk("level", 16'(o_fifo_level), 16'(q.size()));
      chk("ready", 16'(o_byte_ready), 16'(q.size() < D));
      chk("busy", 16'(o_busy), 16'(q.size() > 0 || (emit <= e && e < emit + H + G)));
      if (o_byte_ready !== 1'b1) saw_not_ready = 1'b1;
      if (o_data !== 16'h0) saw_word = 1'b1;
      acc = v && (q.size() < D);
      @(posedge clk);
      if (q.size() > 0 && k >= next_free) begin
         cur = q.pop_front();
         emit = k;
         next_free = k + H + G + 1;
      end
      if (acc) begin
         model_byte(b, p, w);
         if (p) q.push_back(w);
      end
      k++;
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      do begin
         cycle(1'b1, b);
         n++;
      end while (!acc && n < 64);
      if (!acc) chk("send_timeout", 16'(acc), 16'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   function automatic logic [7:0] rnd_byte();
      int r = $urandom_range(99);
      if (r < 45) return ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(127));
      if (r < 60) return 8'h90 + 8'(CH);
      if (r < 70) return 8'h80 + 8'(CH);
      if (r < 74) return 8'h91;
      if (r < 80) return 8'hB0 + 8'(CH);
      if (r < 85) return 8'h7B;
      if (r < 90) return 8'hF8;
      if (r < 93) return 8'hF0;
      if (r < 96) return 8'hA0;
      return 8'hE5;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data", o_data, 16'h0);
      chk("rst_level", 16'(o_fifo_level), 16'h0);
      chk("rst_ready", 16'(o_byte_ready), 16'h1);
      chk("rst_busy", 16'(o_busy), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic note-on and latency / hold / gap
      send(8'h90); send(8'h3C); send(8'h64);
      cycle(1'b0, 8'h00); chk("first_word", o_data, 16'h5E64);
      cycle(1'b0, 8'h00); chk("first_hold", o_data, 16'h5E64);
      cycle(1'b0, 8'h00); chk("first_gap", o_data, 16'h0000);
      idle(4);

      // Running status, repeated identical command
      send(8'h40); send(8'h7F);
      cycle(1'b0, 8'h00); chk("rs_word", o_data, 16'h607F);
      idle(6);
      send(8'h40); send(8'h7F);
      cycle(1'b0, 8'h00); chk("rs_repeat", o_data, 16'h607F);
      idle(6);

      // Note-off forms, foreign channel, interleaved real-time byte
      send(8'h80); send(8'h3C); send(8'h00);
      cycle(1'b0, 8'h00); chk("note_off", o_data, 16'h9E00);
      idle(6);
      send(8'h90); send(8'h3C); send(8'h00);
      cycle(1'b0, 8'h00); chk("on_vel0", o_data, 16'h9E00);
      idle(6);
      send(8'h91); send(8'h3C); send(8'h64);
      cycle(1'b0, 8'h00); chk("other_chan", o_data, 16'h0000);
      idle(4);
      send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
      cycle(1'b0, 8'h00); chk("realtime_skip", o_data, 16'h5E64);
      idle(6);

      // Back-to-back running-status burst fills the FIFO
      saw_not_ready = 1'b0;
      send(8'h90);
      for (int i = 0; i < 10; i++) begin
         send(8'h40 + 8'(i));
         send(8'h50 + 8'(i));
      end
      idle(50);
      chk("fifo_filled", 16'(saw_not_ready), 16'h1);
      chk("burst_drained", 16'(o_busy), 16'h0);

      // Async reset during hold with words queued
      send(8'h90);
      for (int i = 0; i < 4; i++) begin
         send(8'h20 + 8'(i));
         send(8'h30);
      end
      for (int n = 0; n < 20 && !(q.size() == 2 && emit <= k - 1 && k - 1 < emit + H); n++)
         cycle(1'b0, 8'h00);
      rst_n = 1'b0;
      #1;
      chk("async_rst_data", o_data, 16'h0);
      chk("async_rst_level", 16'(o_fifo_level), 16'h0);
      chk("async_rst_ready", 16'(o_byte_ready), 16'h1);
      chk("async_rst_busy", 16'(o_busy), 16'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      saw_word = 1'b0;
      send(8'h3C); send(8'h64);
      idle(8);
      chk("no_rs_after_rst", 16'(saw_word), 16'h0);

      // Controller 123
      send(8'hB0); send(8'h7B); send(8'h00);
      cycle(1'b0, 8'h00);
      chk("all_notes_off", o_data, AON ? 16'hC000 : 16'h0000);
      idle(6);

      // Random streams
      for (int i = 0; i < 800; i++) cycle($urandom_range(3) != 0, rnd_byte());
      idle(60);
      for (int i = 0; i < 400; i++) cycle($urandom_range(3) == 0, rnd_byte());
      idle(60);
      chk("final_idle", 16'(o_busy), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
